mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  M-stage data-memory access unit. Sits between the EX/MEM register and the MEM/WB register.
//  - Turns a decoded load/store into a req/ack transaction on the data bus.
//  - Builds byte enables and store lanes, and sign/zero-extends load data into DM_M.
//  - Stalls the pipeline while a transaction is outstanding.
//  - Reports address-error and bus-timeout exceptions to CP0.
// PARAMETERS
//  DM_BASE      32'h0000_0000  lowest legal data address (inclusive)
//  DM_LIMIT     32'h0000_2FFF  highest legal data address (inclusive)
//  BUS_TIMEOUT  255            cycles in BUSY without bus_ack before a bus error; 0 disables
// PORTS
//  clk         in   1   sole clock, rising edge
//  reset       in   1   asynchronous, active-low reset
//  op_valid    in   1   M-stage instruction is a load or store
//  op_we       in   1   1=store, 0=load
//  op_size     in   2   0=byte, 1=half, 2=word (3 treated as word)
//  op_unsigned in   1   zero-extend loads (lbu/lhu)
//  Addr_M      in   32  effective address from ALU_M
//  WD_M        in   32  store data (rt, forwarded)
//  flush       in   1   exception/eret flush of the M stage
//  bus_req     out  1   transaction request, held until bus_ack
//  bus_we      out  1   write strobe
//  bus_addr    out  32  word address {Addr[31:2],2'b00}
//  bus_be      out  4   byte enables
//  bus_wdata   out  32  lane-replicated store data
//  bus_ack     in   1   transaction complete; rdata valid the same cycle
//  bus_rdata   in   32  read word
//  DM_M        out  32  extended load result, to the MEM/WB register
//  stall_M     out  1   freeze PC, F/D/E/M registers; insert bubble into W
//  exc_valid   out  1   exception request to CP0
//  exc_code    out  5   4=AdEL, 5=AdES, 7=DBE; 0 when exc_valid=0
// BEHAVIOUR
//  Reset: state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, DM_M=0,
//   timer=0, stall_M=0, exc_valid=0, exc_code=0.
//  Illegal address: half with Addr[0]=1, word with Addr[1:0]!=0, or Addr outside [DM_BASE,DM_LIMIT].
//   Flagged combinationally in IDLE when op_valid=1 and flush=0.
//   Response: exc_valid=1, exc_code=AdES if op_we else AdEL, no bus access, stall_M=0.
//  FSM (registered state; stall_M and exc_* are combinational from state and inputs):
//   IDLE:  op_valid & legal & !flush: latch addr/be/wdata/we/size/unsigned/lane,
//          bus_req<=1, timer<=0, go BUSY.
//          stall_M=1 in that same cycle. Otherwise stay in IDLE.
//   BUSY:  stall_M=1; bus outputs held stable; timer increments each cycle.
//          bus_ack=1: bus_req<=0; load: DM_M<=ext(bus_rdata); store: DM_M unchanged.
//            If an abort is pending (see flush), go IDLE; otherwise go DONE.
//          !bus_ack & BUS_TIMEOUT!=0 & timer==BUS_TIMEOUT-1: bus_req<=0, go ERR.
//   DONE:  stall_M=0 for exactly one cycle so the stage advances; go IDLE. Never reissues.
//   ERR:   exc_valid=1, exc_code=7, stall_M=0 for one cycle; go IDLE.
//  Flush in BUSY: the bus transaction is not aborted.
//   Set abort_pending; keep stall_M=1 until bus_ack; result discarded; return to IDLE.
//   abort_pending clears on leaving BUSY.
//  Flush in IDLE: no access starts and no exception is flagged.
//  Store lanes: byte -> {4{WD[7:0]}}, be=4'b0001<<a.
//   half -> {2{WD[15:0]}}, be=4'b0011<<a. word -> WD, be=4'b1111. a=Addr[1:0].
//  Load extract: byte lane a, half lane a[1]. Sign-extend unless op_unsigned. Word passes through.
//  bus_ack while in IDLE/DONE/ERR: ignored. Async reset mid-BUSY drops bus_req immediately.
//  Back-to-back accesses: minimum 3 cycles each (IDLE->BUSY->DONE) with a 1-cycle ack.
// STRUCTURE
//  mem_pkg: size codes (SZ_B/SZ_H/SZ_W), exc codes (EXC_ADEL=4, EXC_ADES=5, EXC_DBE=7),
//   state encoding (IDLE/BUSY/DONE/ERR).
//  Sub-module ld_ext (combinational): {rdata, lane, size, unsigned} -> 32-bit result.
//   Also reused by the bench model.
// TESTING
//  lb @0x0000_0003, unsigned=0, rdata=32'h80AA_BBCC, ack in 1st BUSY cycle
//   -> be=0001<<3=1000, DM_M=32'hFFFF_FF80, stall_M high 2 cycles.
//  sh @0x0000_0102, WD=32'h1234_ABCD -> bus_addr=0x100, be=4'b1100, wdata=32'hABCD_ABCD, bus_we=1.
//  lw @0x0000_0006 -> exc_valid=1, exc_code=4, bus_req never rises, stall_M=0.
//   sw @0x0000_3000 -> exc_code=5.
//  lw with ack withheld, BUS_TIMEOUT=4 -> after 4 BUSY cycles bus_req=0;
//   ERR cycle shows exc_code=7; then IDLE.
//  lhu @0x0000_0002 with flush pulsed in BUSY, ack 3 cycles later
//   -> stall_M held until ack, DONE skipped, DM_M updated but no advance cycle.
//  reset low asserted mid-BUSY -> all outputs 0 asynchronously; a fresh lw after release completes.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the M-stage data-memory access unit.
//   SZ_*    : op_size encodings (3 is treated as word by the users)
//   EXC_*   : CP0 exception codes raised by the unit
//   state_e : access FSM states
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/ld_ext.sv
// Load-data extractor: picks the addressed byte/half out of a bus word and
// sign- or zero-extends it to 32 bits. Words pass through unchanged.
//   rdata       in  32  word returned by the bus
//   lane        in  2   byte offset of the access within the word
//   size        in  2   SZ_B / SZ_H / word (3 treated as word)
//   is_unsigned in  1   zero-extend instead of sign-extend
//   result      out 32  extended load value
module ld_ext
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    unique case (lane)
      2'd0: byte_v = rdata[7:0];
      2'd1: byte_v = rdata[15:8];
      2'd2: byte_v = rdata[23:16];
      2'd3: byte_v = rdata[31:24];
    endcase

    // Halves are aligned, so only lane[1] selects.
    half_v = lane[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      SZ_B:    result = {{24{byte_v[7] & ~is_unsigned}}, byte_v};
      SZ_H:    result = {{16{half_v[15] & ~is_unsigned}}, half_v};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// M-stage data-memory access unit. Converts a decoded load/store into a
// req/ack bus transaction, stalls the pipeline while it is outstanding,
// extends load data into DM_M and raises address/bus-error exceptions.
//   clk, reset           clock (rising edge), async active-low reset
//   op_valid/op_we/op_size/op_unsigned/Addr_M/WD_M   decoded M-stage access
//   flush                M-stage flush from CP0
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata         data-bus request (held until ack)
//   bus_ack/bus_rdata    data-bus completion and read word
//   DM_M                 extended load result to MEM/WB
//   stall_M              pipeline freeze request
//   exc_valid/exc_code   exception request to CP0 (AdEL/AdES/DBE)
module mem_access
  import mem_pkg::*;
#(
  parameter logic [31:0] DM_BASE     = 32'h0000_0000,
  parameter logic [31:0] DM_LIMIT    = 32'h0000_2FFF,
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_we,
  input  logic [1:0]  op_size,
  input  logic        op_unsigned,
  input  logic [31:0] Addr_M,
  input  logic [31:0] WD_M,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] DM_M,
  output logic        stall_M,
  output logic        exc_valid,
  output logic [4:0]  exc_code
);

  // Timer only needs to reach BUS_TIMEOUT-1.
  localparam int unsigned   TimerW    = (BUS_TIMEOUT > 2) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(BUS_TIMEOUT - 1);
  localparam bit            TimeoutEn = (BUS_TIMEOUT != 0);

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       dm_q, dm_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              abort_q, abort_d;

  logic [1:0]  lane;
  logic        misaligned;
  logic [32:0] below_diff;
  logic [32:0] above_diff;
  logic        addr_ok;
  logic        take;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] ld_result;

  assign lane = Addr_M[1:0];

  // 33-bit differences: the borrow bit flags an out-of-window address
  // without a compare that degenerates when DM_BASE is zero.
  assign below_diff = {1'b0, Addr_M} - {1'b0, DM_BASE};
  assign above_diff = {1'b0, DM_LIMIT} - {1'b0, Addr_M};

  always_comb begin
    case (op_size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = lane[0];
      default: misaligned = (lane != 2'd0);
    endcase
  end

  assign addr_ok = !misaligned && !below_diff[32] && !above_diff[32];
  assign take    = (state_q == IDLE) && op_valid && !flush;

  // Store lanes and byte enables; loads use the same enables.
  always_comb begin
    case (op_size)
      SZ_B: begin
        be_n    = 4'b0001 << lane;
        wdata_n = {4{WD_M[7:0]}};
      end
      SZ_H: begin
        be_n    = 4'b0011 << lane;
        wdata_n = {2{WD_M[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = WD_M;
      end
    endcase
  end

  ld_ext u_ld_ext (
    .rdata       (bus_rdata),
    .lane        (lane_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .result      (ld_result)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    lane_d  = lane_q;
    dm_d    = dm_q;
    timer_d = timer_q;
    abort_d = abort_q;

    unique case (state_q)
      IDLE: begin
        if (take && addr_ok) begin
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = op_we;
          addr_d  = {Addr_M[31:2], 2'b00};
          be_d    = be_n;
          wdata_d = wdata_n;
          size_d  = op_size;
          uns_d   = op_unsigned;
          lane_d  = lane;
          timer_d = '0;
          abort_d = 1'b0;
        end
      end
      BUSY: begin
        timer_d = timer_q + TimerW'(1);
        if (flush) begin
          abort_d = 1'b1;
        end
        if (bus_ack) begin
          req_d   = 1'b0;
          abort_d = 1'b0;
          if (!we_q) begin
            dm_d = ld_result;
          end
          // A flush in the ack cycle itself also suppresses the advance cycle.
          state_d = (abort_q || flush) ? IDLE : DONE;
        end else if (TimeoutEn && (timer_q == TimerLast)) begin
          req_d   = 1'b0;
          abort_d = 1'b0;
          state_d = ERR;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_M   = 1'b0;
    exc_valid = 1'b0;
    exc_code  = 5'd0;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          if (addr_ok) begin
            stall_M = 1'b1;
          end else begin
            exc_valid = 1'b1;
            exc_code  = op_we ? EXC_ADES : EXC_ADEL;
          end
        end
      end
      BUSY: stall_M = 1'b1;
      ERR: begin
        exc_valid = 1'b1;
        exc_code  = EXC_DBE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      lane_q  <= '0;
      dm_q    <= '0;
      timer_q <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      lane_q  <= lane_d;
      dm_q    <= dm_d;
      timer_q <= timer_d;
      abort_q <= abort_d;
    end
  end

  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;
  assign DM_M      = dm_q;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_we = 1'b0;
  logic [1:0]  op_size = 2'd0;
  logic        op_unsigned = 1'b0;
  logic [31:0] Addr_M = 32'd0;
  logic [31:0] WD_M = 32'd0;
  logic        flush = 1'b0;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'd0;
  logic [31:0] DM_M;
  logic        stall_M;
  logic        exc_valid;
  logic [4:0]  exc_code;

  always #5 clk = ~clk;

  mem_access #(
    .BUS_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .op_valid    (op_valid),
    .op_we       (op_we),
    .op_size     (op_size),
    .op_unsigned (op_unsigned),
    .Addr_M      (Addr_M),
    .WD_M        (WD_M),
    .flush       (flush),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_be      (bus_be),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata),
    .DM_M        (DM_M),
    .stall_M     (stall_M),
    .exc_valid   (exc_valid),
    .exc_code    (exc_code)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference rules ----------------
  function automatic bit ref_illegal(input logic [31:0] addr, input logic [1:0] size);
    if (addr > 32'h0000_2FFF) return 1'b1;
    if (size == 2'd1) return (addr % 2) != 0;
    if (size >= 2'd2) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] a, input logic [1:0] size);
    if (size == 2'd0) return 4'(1 << a);
    if (size == 2'd1) return 4'(3 << a);
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input logic [1:0] size);
    if (size == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (size == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] ref_ext(input logic [31:0] rd, input logic [1:0] a,
                                          input logic [1:0] size, input bit uns);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (rd >> (8 * a)) & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (rd >> (16 * (a / 2))) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // ---------------- transaction-level model ----------------
  // m_post: 0 nothing, 1 one advance cycle owed, 2 one bus-error cycle owed.
  bit          m_busy, m_abort, m_req, m_we, m_uns;
  int          m_cnt, m_post;
  logic [31:0] m_addr, m_wdata, m_dm;
  logic [3:0]  m_be;
  logic [1:0]  m_size, m_lane;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 0; m_abort <= 0; m_req <= 0; m_we <= 0; m_uns <= 0;
      m_cnt <= 0; m_post <= 0; m_addr <= 0; m_wdata <= 0; m_dm <= 0;
      m_be <= 0; m_size <= 0; m_lane <= 0;
    end else if (m_post != 0) begin
      m_post <= 0;
    end else if (m_busy) begin
      if (bus_ack) begin
        m_req  <= 0;
        m_busy <= 0;
        if (!m_we) m_dm <= ref_ext(bus_rdata, m_lane, m_size, m_uns);
        m_post  <= (m_abort || flush) ? 0 : 1;
        m_abort <= 0;
      end else if (m_cnt == TO - 1) begin
        m_req   <= 0;
        m_busy  <= 0;
        m_post  <= 2;
        m_abort <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
        if (flush) m_abort <= 1;
      end
    end else if (op_valid && !flush && !ref_illegal(Addr_M, op_size)) begin
      m_busy  <= 1;
      m_req   <= 1;
      m_cnt   <= 0;
      m_abort <= 0;
      m_we    <= op_we;
      m_addr  <= Addr_M & 32'hFFFF_FFFC;
      m_be    <= ref_be(Addr_M[1:0], op_size);
      m_wdata <= ref_wdata(WD_M, op_size);
      m_size  <= op_size;
      m_uns   <= op_unsigned;
      m_lane  <= Addr_M[1:0];
    end
  end

  // Compare every cycle, mid-cycle, against the model.
  always @(negedge clk) begin
    bit         e_stall, e_exc;
    logic [4:0] e_code;
    if (reset && chk_en) begin
      e_stall = 0; e_exc = 0; e_code = 0;
      if (m_post == 1) begin
        e_stall = 0;
      end else if (m_post == 2) begin
        e_exc = 1; e_code = 5'd7;
      end else if (m_busy) begin
        e_stall = 1;
      end else if (op_valid && !flush) begin
        if (ref_illegal(Addr_M, op_size)) begin
          e_exc = 1; e_code = op_we ? 5'd5 : 5'd4;
        end else begin
          e_stall = 1;
        end
      end
      check("m_stall", stall_M, e_stall);
      check("m_exc_valid", exc_valid, e_exc);
      check("m_exc_code", exc_code, e_code);
      check("m_bus_req", bus_req, m_req);
      check("m_DM_M", DM_M, m_dm);
      if (m_req) begin
        check("m_bus_we", bus_we, m_we);
        check("m_bus_addr", bus_addr, m_addr);
        check("m_bus_be", bus_be, m_be);
        check("m_bus_wdata", bus_wdata, m_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input bit v, input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd);
    op_valid = v; op_we = we; op_size = sz; op_unsigned = uns; Addr_M = addr; WD_M = wd;
  endtask

  initial begin
    int cnt;
    int sel;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_be", bus_be, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_DM_M", DM_M, 0);
    check("rst_stall", stall_M, 0);
    check("rst_exc", {exc_valid, exc_code}, 0);
    reset = 1'b1;
    chk_en = 1'b1;
    tick();

    // lb @3, sign-extended, ack in first BUSY cycle.
    set_op(1, 0, 2'd0, 0, 32'h0000_0003, 32'h5555_5555);
    @(negedge clk);
    check("lb_issue_stall", stall_M, 1);
    check("lb_issue_req", bus_req, 0);
    tick();
    bus_ack = 1; bus_rdata = 32'h80AA_BBCC;
    @(negedge clk);
    check("lb_busy_stall", stall_M, 1);
    check("lb_be", bus_be, 4'b1000);
    check("lb_addr", bus_addr, 0);
    tick();
    bus_ack = 0; op_valid = 0;
    @(negedge clk);
    check("lb_done_stall", stall_M, 0);
    check("lb_DM_M", DM_M, 32'hFFFF_FF80);
    tick();

    // sh @0x102.
    set_op(1, 1, 2'd1, 0, 32'h0000_0102, 32'h1234_ABCD);
    tick();
    op_valid = 0;
    @(negedge clk);
    check("sh_addr", bus_addr, 32'h100);
    check("sh_be", bus_be, 4'b1100);
    check("sh_wdata", bus_wdata, 32'hABCD_ABCD);
    check("sh_we", bus_we, 1);
    tick();
    bus_ack = 1;
    tick();
    bus_ack = 0;
    @(negedge clk);
    check("sh_done_stall", stall_M, 0);
    tick();

    // Address errors.
    set_op(1, 0, 2'd2, 0, 32'h0000_0006, 32'h0);
    @(negedge clk);
    check("lw_mis_exc", exc_valid, 1);
    check("lw_mis_code", exc_code, 4);
    check("lw_mis_stall", stall_M, 0);
    tick();
    set_op(1, 1, 2'd2, 0, 32'h0000_3000, 32'h0);
    @(negedge clk);
    check("sw_oor_code", exc_code, 5);
    check("sw_oor_req", bus_req, 0);
    tick();
    op_valid = 0;

    // Bus timeout.
    set_op(1, 0, 2'd2, 0, 32'h0000_0040, 32'h0);
    tick();
    op_valid = 0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus_req) break;
      cnt++;
      tick();
    end
    check("to_busy_cycles", cnt, 4);
    check("to_exc_code", exc_code, 7);
    check("to_stall", stall_M, 0);
    tick();
    @(negedge clk);
    check("to_idle_exc", exc_valid, 0);
    tick();

    // lhu @2 with flush in BUSY; ack three cycles later.
    set_op(1, 0, 2'd1, 1, 32'h0000_0002, 32'h0);
    tick();
    op_valid = 0; flush = 1;
    @(negedge clk);
    check("fl_stall1", stall_M, 1);
    tick();
    flush = 0;
    tick();
    tick();
    bus_ack = 1; bus_rdata = 32'h9876_1234;
    @(negedge clk);
    check("fl_stall_ack", stall_M, 1);
    tick();
    bus_ack = 0;
    set_op(1, 0, 2'd2, 0, 32'h0000_0020, 32'h0);
    @(negedge clk);
    check("fl_no_done", stall_M, 1);
    check("fl_DM_M", DM_M, 32'h0000_9876);
    tick();
    op_valid = 0; bus_ack = 1; bus_rdata = 32'hCAFE_F00D;
    tick();
    bus_ack = 0;
    @(negedge clk);
    check("lw_after_fl", DM_M, 32'hCAFE_F00D);
    tick();

    // Async reset mid-BUSY, then a fresh lw.
    set_op(1, 0, 2'd2, 0, 32'h0000_0030, 32'h0);
    tick();
    op_valid = 0;
    #2 reset = 0;
    #1;
    check("ar_req", bus_req, 0);
    check("ar_stall", stall_M, 0);
    check("ar_DM_M", DM_M, 0);
    check("ar_bus", {bus_we, bus_be, bus_addr, bus_wdata} == 0, 1);
    tick();
    reset = 1;
    set_op(1, 0, 2'd2, 0, 32'h0000_0010, 32'h0);
    tick();
    op_valid = 0; bus_ack = 1; bus_rdata = 32'h1122_3344;
    tick();
    bus_ack = 0;
    @(negedge clk);
    check("ar_fresh_lw", DM_M, 32'h1122_3344);
    tick();

    // Randomized traffic against the model.
    repeat (3000) begin
      sel = $urandom_range(0, 9);
      op_valid    = ($urandom_range(0, 3) != 0);
      op_we       = 1'($urandom_range(0, 1));
      op_size     = 2'($urandom_range(0, 3));
      op_unsigned = 1'($urandom_range(0, 1));
      if (sel == 0) Addr_M = 32'h0000_3000 + $urandom_range(0, 255);
      else if (sel == 1) Addr_M = $urandom();
      else Addr_M = $urandom_range(0, 32'h2FFF);
      WD_M      = $urandom();
      flush     = ($urandom_range(0, 9) == 0);
      bus_ack   = 1'($urandom_range(0, 1));
      bus_rdata = $urandom();
      tick();
    end
    set_op(0, 0, 2'd0, 0, 32'h0, 32'h0);
    flush = 0; bus_ack = 0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
